// File: rtl/alu_pkg.sv
// Constants and types shared by the ALU and the multi-cycle multiply/divide unit
// in the execute stage.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

endpackage

// File: rtl/negate32.sv
// Two's-complement negate. Used for the divide operand magnitudes and the
// quotient sign fix.
module negate32 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] negated
);

  assign negated = ~value + WIDTH'(1);

endmodule

// File: rtl/multdiv.sv
// Multi-cycle signed multiply (radix-2 Booth) and divide (restoring, on
// magnitudes) sharing one adder/subtractor. One step per cycle.
module multdiv #(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  import alu_pkg::*;

  md_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             start, last, fin;

  // acc is the Booth upper half / divide remainder; q is the multiplier /
  // dividend that shifts out while product low half / quotient shifts in.
  logic signed [WIDTH:0] acc;
  logic [WIDTH-1:0]      q, m;
  logic                  qm1, neg, dz, ovf;

  logic [WIDTH-1:0] neg_a, neg_b, neg_q, abs_a, abs_b;
  logic [1:0]       booth;
  logic signed [WIDTH:0] add_x, add_y, add_sum;
  logic                  add_sub;
  logic [WIDTH:0]        hi;
  logic [WIDTH-1:0]      res_nxt;
  logic                  exc_nxt;

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (cnt == CNT_W'(WIDTH));
  assign booth = {q[0], qm1};

  negate32 #(.WIDTH(WIDTH)) u_neg_a (.value(data_operandA), .negated(neg_a));
  negate32 #(.WIDTH(WIDTH)) u_neg_b (.value(data_operandB), .negated(neg_b));
  negate32 #(.WIDTH(WIDTH)) u_neg_q (.value(q),             .negated(neg_q));

  assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

  // Shared adder: Booth add/sub of the multiplicand, or trial subtract of the
  // divisor from the shifted remainder. One extra bit keeps both exact.
  always_comb begin
    add_x   = acc;
    add_y   = '0;
    add_sub = 1'b0;
    if (state == DIV) begin
      add_x   = {acc[WIDTH-1:0], q[WIDTH-1]};
      add_y   = {1'b0, m};
      add_sub = 1'b1;
    end else begin
      add_y   = (booth[1] ^ booth[0]) ? {m[WIDTH-1], m} : '0;
      add_sub = (booth == 2'b10);
    end
    add_sum = add_x + (add_sub ? ~add_y : add_y) + {{WIDTH{1'b0}}, add_sub};
  end

  always_ff @(posedge clock) begin
    if (start) begin
      acc <= '0;
      qm1 <= 1'b0;
      neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      dz  <= (data_operandB == '0);
      ovf <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      if (ctrl_MULT) begin
        m <= data_operandA;
        q <= data_operandB;
      end else begin
        m <= abs_b;
        q <= abs_a;
      end
    end else if (state == MUL && !last) begin
      acc <= {add_sum[WIDTH], add_sum[WIDTH:1]};
      q   <= {add_sum[0], q[WIDTH-1:1]};
      qm1 <= q[0];
    end else if (state == DIV && !last) begin
      if (!add_sum[WIDTH]) begin
        acc <= add_sum;
        q   <= {q[WIDTH-2:0], 1'b1};
      end else begin
        acc <= add_x;
        q   <= {q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Result formatting on the cycle that enters DONE.
  always_comb begin
    hi      = {acc[WIDTH-1:0], q[WIDTH-1]};
    res_nxt = q;
    exc_nxt = ~((&hi) | ~(|hi));
    if (state == DIV) begin
      res_nxt = dz ? '0 : (neg ? neg_q : q);
      exc_nxt = dz | ovf;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state)
        MUL:     if (last) state_nxt = DONE;
        DIV:     if (dz || last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
    busy           = (state == MUL) || (state == DIV);
    data_resultRDY = (state == DONE);
    fin            = busy && (state_nxt == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      if (start)             cnt <= '0;
      else if (busy && !last) cnt <= cnt + CNT_W'(1);
      if (fin) begin
        data_result    <= res_nxt;
        data_exception <= exc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Bench for multdiv: vector table plus abort, back-to-back and reset sequences,
// with a completion scoreboard keyed on the expected edge of the ready pulse.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY, busy;

  multdiv dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  int edge_no = 0;
  always @(posedge clock) edge_no <= edge_no + 1;

  typedef struct { logic [31:0] res; logic exc; int due; } exp_t;
  typedef struct { int op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic exc; int lat; } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  function automatic vec_t mk(input int op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic exc, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.exc = exc; v.lat = lat;
    return v;
  endfunction

  always @(negedge clock) begin
    if (data_resultRDY) begin
      if (sb.size() == 0) begin
        check("unexpected_rdy", 32'(data_resultRDY), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", data_result, e.res);
        check("exception", 32'(data_exception), 32'(e.exc));
        check("rdy_edge", 32'(edge_no), 32'(e.due));
      end
    end
  end

  // op: 0 = multiply, 1 = divide, 2 = both start pulses high.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic exc, input int lat);
    int s;
    @(negedge clock);
    s = edge_no + 1;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = (op != 1);
    ctrl_DIV  = (op != 0);
    sb.push_back('{res: res, exc: exc, due: s + lat});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) @(negedge clock);
      check("busy", 32'(busy), 32'(k < lat));
    end
    @(negedge clock);
    check("pending", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;

    vecs.push_back(mk(0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33));
    vecs.push_back(mk(0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, 33));
    vecs.push_back(mk(0, 32'h7FFFFFFF, 32'd1,        32'h7FFFFFFF, 1'b0, 33));
    vecs.push_back(mk(0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 33));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33));
    vecs.push_back(mk(0, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33));
    vecs.push_back(mk(0, 32'hFFFF0000, 32'h00010000, 32'h00000000, 1'b1, 33));
    vecs.push_back(mk(1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33));
    vecs.push_back(mk(1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 33));
    vecs.push_back(mk(1, 32'd3,        32'd5,        32'h00000000, 1'b0, 33));
    vecs.push_back(mk(1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       1'b0, 33));
    vecs.push_back(mk(1, 32'h80000000, 32'd1,        32'h80000000, 1'b0, 33));
    vecs.push_back(mk(1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 33));
    vecs.push_back(mk(1, 32'd5,        32'd0,        32'h00000000, 1'b1, 1));
    vecs.push_back(mk(1, 32'd0,        32'd0,        32'h00000000, 1'b1, 1));
    vecs.push_back(mk(1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 33));
    vecs.push_back(mk(2, 32'd6,        32'd2,        32'd12,       1'b0, 33));

    repeat (3) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_exception", 32'(data_exception), 32'd0);
    check("reset_rdy", 32'(data_resultRDY), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc, vecs[i].lat);

    // Divide aborted by a multiply started at edge 5.
    @(negedge clock);
    s = edge_no + 1;
    data_operandA = 32'd100; data_operandB = 32'd3; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (4) @(negedge clock);
    data_operandA = 32'd3; data_operandB = 32'd4; ctrl_MULT = 1'b1;
    sb.push_back('{res: 32'd12, exc: 1'b0, due: s + 38});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (40) @(negedge clock);
    check("abort_pending", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();

    // Start sampled in the DONE cycle; the finishing pulse must still appear.
    @(negedge clock);
    s = edge_no + 1;
    data_operandA = 32'd2; data_operandB = 32'd3; ctrl_MULT = 1'b1;
    sb.push_back('{res: 32'd6, exc: 1'b0, due: s + 33});
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (33) @(negedge clock);
    check("b2b_rdy", 32'(data_resultRDY), 32'd1);
    data_operandA = 32'd20; data_operandB = 32'd4; ctrl_DIV = 1'b1;
    sb.push_back('{res: 32'd5, exc: 1'b0, due: s + 67});
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (36) @(negedge clock);
    check("b2b_pending", 32'(sb.size()), 32'd0);
    if (sb.size() != 0) sb.delete();

    // Reset in cycle 10 of a multiply.
    @(negedge clock);
    data_operandA = 32'd5; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (9) @(negedge clock);
    check("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_reset_result", data_result, 32'd0);
    check("mid_reset_exception", 32'(data_exception), 32'd0);
    check("mid_reset_rdy", 32'(data_resultRDY), 32'd0);
    check("mid_reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check("post_reset_idle", 32'(busy), 32'd0);
    run_op(0, 32'd2, 32'd2, 32'd4, 1'b0, 33);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
